fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754 multiplier with a valid/ready handshake on both sides, a passthrough tag and a sticky exception register.
- Successor to the single-cycle combinational DW_fp_mult usage in the 16-bit pipelined processor. Sits between the operand-read stage and writeback of the FP datapath.
- Rounding mode is carried per transaction, so back-to-back operations may use different modes.

Parameters:
- sig_width, 23, fraction bits (excluding hidden bit)
- exp_width, 8, exponent bits; bias = 2^(exp_width-1)-1
- tag_width, 4, width of the tag carried alongside each operation

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair is valid
- in_ready  output  1  pipe accepts the operand pair this cycle
- inst_a  input  sig_width+exp_width+1  operand A
- inst_b  input  sig_width+exp_width+1  operand B
- inst_rnd  input  3  rounding mode: 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf; 4-7 treated as RNE
- in_tag  input  tag_width  user tag
- out_valid  output  1  result is valid
- out_ready  input  1  consumer takes the result
- z_inst  output  sig_width+exp_width+1  product
- status_inst  output  8  [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] always 0
- out_tag  output  tag_width  tag of the result
- sticky_status  output  8  OR of status_inst over all accepted results since reset/clear
- sticky_clr  input  1  clears sticky_status

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits, out_valid, z_inst, status_inst, out_tag and sticky_status go to 0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- Pipeline: 3 stages. Global advance signal adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_valid and out_ready.
  - Accept occurs when in_valid & in_ready; a result pops when out_valid & out_ready.
  - If adv=0, all stages hold. Bubbles are not collapsed.
  - Latency is exactly 3 cycles with no stall: accepted at edge N, out_valid=1 after edge N+3.
  - Throughput is 1 operation per cycle.
- Stage 1, unpack/classify:
  - Denormal inputs are flushed to zero (sign kept).
  - Flags NaN, inf and zero per operand.
  - Result sign = sA^sB.
  - Exponent sum = eA+eB-bias, held in a signed value of exp_width+2 bits.
- Stage 2: (sig_width+1)x(sig_width+1) mantissa multiply giving a 2*sig_width+2 bit product.
- Stage 3, normalize/round/pack:
  - If product MSB=1, shift right 1 and increment exponent.
  - Guard and sticky bits are taken from the discarded bits; round per mode.
  - Mantissa carry-out on rounding renormalises (exponent+1).
- Special cases (priority top-down):
  - Any NaN, or inf*0 -> z = canonical qNaN (sign 0, exp all 1, fraction MSB 1, rest 0); invalid=1.
  - inf*finite-nonzero or inf*inf -> inf with xor sign; inf=1.
  - zero*finite -> signed zero; zero=1.
- Overflow (biased exponent >= 2^exp_width-1 after rounding):
  - huge=1, inexact=1.
  - Result is inf for RNE; inf for +inf mode when positive; inf for -inf mode when negative.
  - Otherwise the result is the max finite value with xor sign; inf flag set only when the result is inf.
- Underflow (biased exponent <= 0 before rounding):
  - Result flushed to signed zero; tiny=1, inexact=1, zero=1.
- inexact=1 whenever any discarded bit was nonzero.
- sticky_status:
  - On each pop: sticky_status |= status_inst.
  - sticky_clr=1 at the same edge as a pop: the result is sticky = status_inst of that pop (clear first, then OR).
- out_tag always matches the tag accepted with the same operand pair.
- Stable while stalled: z_inst, status_inst and out_tag hold while out_valid=1 and out_ready=0.

Test Plan:
- 0x3FC00000 * 0x40000000, rnd=0 -> 0x40400000, status 0x00, latency 3, out_tag equals in_tag.
- 0x3F800001 * 0x3F800001: rnd=0 -> 0x3F800002; rnd=2 -> 0x3F800003; rnd=1 -> 0x3F800002; status 0x20 in each case. Issue back-to-back on consecutive cycles.
- 0x7F000000 * 0x7F000000: rnd=0 -> 0x7F800000 status 0x32; rnd=1 -> 0x7F7FFFFF status 0x30. 0xFF000000*0x7F000000 with rnd=2 -> 0xFF7FFFFF.
- 0x7F800000 * 0x00000000 -> 0x7FC00000 status 0x04. 0x00800000 * 0x3F000000 -> 0x00000000 status 0x29. sticky_status = 0x2D afterwards; sticky_clr -> 0x00.
- Stream 10 tagged ops with out_ready toggling pseudo-randomly. Checks:
  - No loss or duplication, in order.
  - z_inst is stable while stalled.
  - in_ready=0 exactly when out_valid=1 and out_ready=0.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 and sticky_status=0 next cycle. First op accepted after reset emerges 3 cycles later, correct.

Source files
------------

// File: rtl/fp_mult_pipe_if.sv
// rtl/fp_mult_pipe_if.sv - operand/result handshake bundle for fp_mult_pipe
interface fp_mult_pipe_if #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int tag_width = 4
);
  localparam int w = sig_width + exp_width + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [w-1:0]         inst_a;
  logic [w-1:0]         inst_b;
  logic [2:0]           inst_rnd;
  logic [tag_width-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [w-1:0]         z_inst;
  logic [7:0]           status_inst;
  logic [tag_width-1:0] out_tag;
  logic [7:0]           sticky_status;
  logic                 sticky_clr;

  modport master (
    output in_valid, inst_a, inst_b, inst_rnd, in_tag, out_ready, sticky_clr,
    input  in_ready, out_valid, z_inst, status_inst, out_tag, sticky_status
  );

  modport slave (
    input  in_valid, inst_a, inst_b, inst_rnd, in_tag, out_ready, sticky_clr,
    output in_ready, out_valid, z_inst, status_inst, out_tag, sticky_status
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - pipelined IEEE-754 multiplier with tag passthrough and sticky status
module fp_mult_pipe #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int tag_width = 4
) (
  input logic           clk,
  input logic           rst,
  fp_mult_pipe_if.slave bus
);
  localparam int w  = sig_width + exp_width + 1;
  localparam int mw = sig_width + 1;
  localparam int pw = 2 * sig_width + 2;
  localparam int ew = exp_width + 2;
  localparam logic [exp_width-1:0]       emax     = '1;
  localparam logic [exp_width-1:0]       emax_m1  = {{(exp_width-1){1'b1}}, 1'b0};
  localparam logic [ew-1:0]              bias_v   = ew'((1 << (exp_width - 1)) - 1);
  localparam logic signed [ew-1:0]       exp_ovf  = ew'((1 << exp_width) - 1);
  localparam logic signed [ew-1:0]       exp_zero = '0;

  logic adv, pop;
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign pop          = bus.out_valid & bus.out_ready;
  assign bus.in_ready = adv;

  logic                 sa, sb;
  logic [exp_width-1:0] ea, eb;
  logic [sig_width-1:0] fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [ew-1:0]        exp_sum;
  assign {sa, ea, fa} = bus.inst_a;
  assign {sb, eb, fb} = bus.inst_b;
  // Exponent 0 covers both true zero and denormals, which are flushed.
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == emax) && (fa == '0);
  assign b_inf   = (eb == emax) && (fb == '0);
  assign a_nan   = (ea == emax) && (fa != '0);
  assign b_nan   = (eb == emax) && (fb != '0);
  assign exp_sum = {2'b00, ea} + {2'b00, eb} - bias_v;

  logic                   v1, v2, v3;
  logic                   s1_sign, s1_inv, s1_inf, s1_zero;
  logic                   s2_sign, s2_inv, s2_inf, s2_zero;
  logic                   s3_sign, s3_inv, s3_inf, s3_zero;
  logic signed [ew-1:0]   s1_exp, s2_exp, s3_exp;
  logic [2:0]             s1_rnd, s2_rnd, s3_rnd;
  logic [tag_width-1:0]   s1_tag, s2_tag, s3_tag;
  logic [mw-1:0]          s1_ma, s1_mb;
  logic [pw-1:0]          s2_prod;
  logic [sig_width-1:0]   s3_frac;
  logic                   s3_g, s3_s;

  logic [sig_width-1:0]   norm_frac;
  logic                   norm_g, norm_s;
  logic signed [ew-1:0]   norm_exp;

  always_comb begin
    norm_frac = s2_prod[pw-3 -: sig_width];
    norm_g    = s2_prod[sig_width-1];
    norm_s    = |s2_prod[sig_width-2:0];
    norm_exp  = s2_exp;
    if (s2_prod[pw-1]) begin
      norm_frac = s2_prod[pw-2 -: sig_width];
      norm_g    = s2_prod[sig_width];
      norm_s    = |s2_prod[sig_width-1:0];
      norm_exp  = s2_exp + ew'(1);
    end
  end

  logic                 lost, rnd_up, ovf_inf;
  logic [sig_width:0]   frac_rnd;
  logic signed [ew-1:0] exp_rnd;
  logic [w-1:0]         pack_z;
  logic [7:0]           pack_st;

  always_comb begin
    lost = s3_g | s3_s;
    case (s3_rnd)
      3'd1:    rnd_up = 1'b0;
      3'd2:    rnd_up = lost & ~s3_sign;
      3'd3:    rnd_up = lost & s3_sign;
      default: rnd_up = s3_g & (s3_s | s3_frac[0]);
    endcase
    frac_rnd = {1'b0, s3_frac} + {{sig_width{1'b0}}, rnd_up};
    exp_rnd  = s3_exp + ew'(frac_rnd[sig_width]);
    // Overflow saturates to max finite only when rounding points back toward zero.
    ovf_inf  = ~((s3_rnd == 3'd1) | ((s3_rnd == 3'd2) & s3_sign) | ((s3_rnd == 3'd3) & ~s3_sign));
    pack_z   = {s3_sign, exp_rnd[exp_width-1:0], frac_rnd[sig_width-1:0]};
    pack_st  = 8'h00;
    if (s3_inv) begin
      pack_z     = {1'b0, emax, 1'b1, {(sig_width-1){1'b0}}};
      pack_st[2] = 1'b1;
    end else if (s3_inf) begin
      pack_z     = {s3_sign, emax, {sig_width{1'b0}}};
      pack_st[1] = 1'b1;
    end else if (s3_zero) begin
      pack_z     = {s3_sign, {(w-1){1'b0}}};
      pack_st[0] = 1'b1;
    end else if (s3_exp <= exp_zero) begin
      pack_z     = {s3_sign, {(w-1){1'b0}}};
      pack_st[0] = 1'b1;
      pack_st[3] = 1'b1;
      pack_st[5] = 1'b1;
    end else if (exp_rnd >= exp_ovf) begin
      pack_z     = ovf_inf ? {s3_sign, emax, {sig_width{1'b0}}}
                           : {s3_sign, emax_m1, {sig_width{1'b1}}};
      pack_st[1] = ovf_inf;
      pack_st[4] = 1'b1;
      pack_st[5] = 1'b1;
    end else begin
      pack_st[5] = lost;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= sa ^ sb;
      s1_inv  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf  <= a_inf | b_inf;
      s1_zero <= a_zero | b_zero;
      s1_exp  <= exp_sum;
      s1_ma   <= a_zero ? '0 : {1'b1, fa};
      s1_mb   <= b_zero ? '0 : {1'b1, fb};
      s1_rnd  <= bus.inst_rnd;
      s1_tag  <= bus.in_tag;
      {s2_sign, s2_inv, s2_inf, s2_zero} <= {s1_sign, s1_inv, s1_inf, s1_zero};
      s2_exp  <= s1_exp;
      s2_prod <= pw'(s1_ma) * pw'(s1_mb);
      s2_rnd  <= s1_rnd;
      s2_tag  <= s1_tag;
      {s3_sign, s3_inv, s3_inf, s3_zero} <= {s2_sign, s2_inv, s2_inf, s2_zero};
      s3_exp  <= norm_exp;
      s3_frac <= norm_frac;
      s3_g    <= norm_g;
      s3_s    <= norm_s;
      s3_rnd  <= s2_rnd;
      s3_tag  <= s2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1                <= 1'b0;
      v2                <= 1'b0;
      v3                <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.z_inst        <= '0;
      bus.status_inst   <= '0;
      bus.out_tag       <= '0;
      bus.sticky_status <= '0;
    end else begin
      if (adv) begin
        v1            <= bus.in_valid;
        v2            <= v1;
        v3            <= v2;
        bus.out_valid <= v3;
        if (v3) begin
          bus.z_inst      <= pack_z;
          bus.status_inst <= pack_st;
          bus.out_tag     <= s3_tag;
        end
      end
      bus.sticky_status <= (bus.sticky_clr ? 8'h00 : bus.sticky_status) |
                           (pop ? bus.status_inst : 8'h00);
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - scoreboard bench for fp_mult_pipe
module tb_fp_mult_pipe;
  logic clk;
  logic rst;

  fp_mult_pipe_if #(.sig_width(23), .exp_width(8), .tag_width(4)) bus ();
  fp_mult_pipe #(.sig_width(23), .exp_width(8), .tag_width(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] z;
    logic [7:0]  st;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb_q[$];
  int          total  = 0;
  int          bad    = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  logic        rand_ready = 1'b0;
  logic [31:0] va [0:18];
  logic [31:0] vb [0:18];
  logic [2:0]  vr [0:18];
  logic [31:0] vz [0:18];
  logic [7:0]  vs [0:18];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int i, input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.inst_a   = va[i];
    bus.inst_b   = vb[i];
    bus.inst_rnd = vr[i];
    bus.in_tag   = t;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back('{vz[i], vs[i], t});
        n_push++;
        tick();
        bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("send_budget", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && k < 300) begin
      tick();
      k++;
    end
    chk("drain_budget", 32'(k < 300), 32'd1);
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 32'(lat), 32'd3);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic        prev_stall;
    logic        exp_rdy;
    logic [31:0] pz;
    logic [7:0]  ps;
    logic [3:0]  pt;
    exp_t        e;
    prev_stall = 1'b0;
    pz = '0;
    ps = '0;
    pt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        exp_rdy = ~bus.out_valid | bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_z", bus.z_inst, pz);
          chk("stall_status", 32'(bus.status_inst), 32'(ps));
          chk("stall_tag", 32'(bus.out_tag), 32'(pt));
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("pop_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_pop++;
            chk("z_inst", bus.z_inst, e.z);
            chk("status_inst", 32'(bus.status_inst), 32'(e.st));
            chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
          end
        end
        prev_stall = bus.out_valid & ~bus.out_ready;
        pz = bus.z_inst;
        ps = bus.status_inst;
        pt = bus.out_tag;
      end
    end
  end

  initial begin
    va = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000,
           32'h7F000000, 32'hFF000000, 32'h7F800000, 32'h00800000, 32'h3FFFFFFE,
           32'h3FFFFFFE, 32'hBF800001, 32'h3F800001, 32'h80000000, 32'hFF800000,
           32'h7FC00000, 32'h00000001, 32'h7F000000, 32'h7F000000};
    vb = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000,
           32'h7F000000, 32'h7F000000, 32'h00000000, 32'h3F000000, 32'h3F800001,
           32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800000, 32'h3F800000,
           32'h3F800000, 32'h7F000000, 32'h7F000000, 32'h7F000000};
    vr = '{3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0,
           3'd1, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
    vz = '{32'h40400000, 32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h7F800000,
           32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FC00000, 32'h00000000, 32'h40000000,
           32'h3FFFFFFF, 32'hBF800003, 32'h3F800002, 32'h80000000, 32'hFF800000,
           32'h7FC00000, 32'h00000000, 32'h7F7FFFFF, 32'h7F800000};
    vs = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h32, 8'h30, 8'h30, 8'h04, 8'h29, 8'h20,
           8'h20, 8'h20, 8'h20, 8'h01, 8'h02, 8'h04, 8'h01, 8'h30, 8'h32};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.inst_a     = '0;
    bus.inst_b     = '0;
    bus.inst_rnd   = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_z_inst", bus.z_inst, 32'd0);
    chk("rst_status", 32'(bus.status_inst), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_sticky", 32'(bus.sticky_status), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(0, 4'h3);
    measure_latency("latency_first");

    send(1, 4'h1);
    send(2, 4'h2);
    send(3, 4'h4);
    drain();

    send(4, 4'h5);
    send(5, 4'h6);
    send(6, 4'h7);
    send(17, 4'h8);
    send(18, 4'h9);
    drain();

    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_after_clr", 32'(bus.sticky_status), 32'd0);
    @(posedge clk);
    #1;
    send(7, 4'hA);
    send(8, 4'hB);
    drain();
    @(negedge clk);
    chk("sticky_accum", 32'(bus.sticky_status), 32'h2D);
    @(posedge clk);
    #1;
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_idle", 32'(bus.sticky_status), 32'd0);
    @(posedge clk);
    #1;

    send(7, 4'hC);
    drain();
    bus.out_ready = 1'b0;
    send(4, 4'hD);
    for (int k = 0; k < 20 && !bus.out_valid; k++) tick();
    chk("stall_wait_valid", 32'(bus.out_valid), 32'd1);
    tick();
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_with_pop", 32'(bus.sticky_status), 32'h32);
    @(posedge clk);
    #1;

    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(9 + i, 4'(i + 2));
    drain();
    chk("stream_count", 32'(n_pop), 32'(n_push));

    send(0, 4'hA);
    send(1, 4'hB);
    rst = 1'b1;
    n_push -= sb_q.size();
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flight_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_flight_sticky", 32'(bus.sticky_status), 32'd0);
    @(posedge clk);
    #1;
    send(2, 4'hE);
    measure_latency("latency_after_reset");
    repeat (6) tick();
    chk("final_count", 32'(n_pop), 32'(n_push));
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
